// File: rtl/rc4_search_controller_if.sv
// Handshake and data bundle between the RC4 search controller and the board/core array.
interface rc4_search_controller_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned KEY_W     = 24,
  parameter int unsigned IDX_W     = 4
);
  logic                       start;
  logic                       rom_load_start;
  logic                       rom_load_done;
  logic                       core_start;
  logic                       core_stop;
  logic [NUM_CORES*KEY_W-1:0] core_base_key;
  logic [KEY_W-1:0]           core_key_step;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0]       core_found;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic                       wb_start;
  logic                       wb_done;
  logic [IDX_W-1:0]           wb_sel;
  logic                       busy;
  logic                       found_valid;
  logic [KEY_W-1:0]           found_key;
  logic [IDX_W-1:0]           found_index;
  logic                       not_found;
  logic                       timeout;

  modport master (
    input  start, rom_load_done, core_done, core_found, core_key, wb_done,
    output rom_load_start, core_start, core_stop, core_base_key, core_key_step,
           wb_start, wb_sel, busy, found_valid, found_key, found_index, not_found, timeout
  );

  modport slave (
    output start, rom_load_done, core_done, core_found, core_key, wb_done,
    input  rom_load_start, core_start, core_stop, core_base_key, core_key_step,
           wb_start, wb_sel, busy, found_valid, found_key, found_index, not_found, timeout
  );
endinterface

// File: rtl/rc4_search_controller.sv
// RC4 key-search sequencer: ROM load, core launch, found/done arbitration, writeback.
// Optional macro SEARCH_TIMEOUT_EN adds a TIMEOUT_CYC limit on the SEARCH state.
module rc4_search_controller #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned KEY_W       = 24,
  parameter int unsigned SEARCH_W    = 22,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 2**26
) (
  input logic                     CLOCK_50,
  input logic                     reset_n,
  rc4_search_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_SEARCH, S_STOP, S_WB, S_FOUND, S_EXHAUSTED
  } state_t;

  localparam logic [KEY_W-1:0] KEY_ONES = '1;
  localparam logic [KEY_W-1:0] KEY_MASK = KEY_ONES >> (KEY_W - SEARCH_W);

  if (NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_cores
    $error("NUM_CORES must be 1..16");
  end
  if (IDX_W < $clog2(NUM_CORES) || IDX_W < 1) begin : g_bad_idx
    $error("IDX_W too narrow for NUM_CORES");
  end
  if (SEARCH_W > KEY_W || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("SEARCH_W must not exceed KEY_W and TIMEOUT_CYC must be >= 1");
  end

  state_t           state_q, state_d;
  logic             core_start_q;
  logic             timeout_q;
  logic [IDX_W-1:0] found_index_q;
  logic [KEY_W-1:0] found_key_q;
  logic [IDX_W-1:0] hit_idx;
  logic [KEY_W-1:0] hit_key;
  logic             armed;
  logic             hit;
  logic             all_done;
  logic             limit;

  // Core flags are stale until the cores have seen core_start, so the
  // first SEARCH cycle (core_start high) does not arbitrate.
  assign armed    = ~core_start_q;
  assign hit      = armed & (|bus.core_found);
  assign all_done = armed & (&bus.core_done);

  // Lowest-numbered finder wins.
  always_comb begin
    hit_idx = '0;
    hit_key = '0;
    for (int unsigned i = NUM_CORES; i > 0; i--) begin
      if (bus.core_found[i-1]) begin
        hit_idx = IDX_W'(i - 1);
        hit_key = bus.core_key[(i-1)*KEY_W +: KEY_W];
      end
    end
  end

`ifdef SEARCH_TIMEOUT_EN
  logic [31:0] search_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      search_cnt <= '0;
    end else if (state_q != S_SEARCH) begin
      search_cnt <= '0;
    end else begin
      search_cnt <= search_cnt + 32'd1;
    end
  end

  assign limit = (state_q == S_SEARCH) && (search_cnt == 32'(TIMEOUT_CYC - 1));
`else
  assign limit = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.rom_load_start = 1'b0;
    bus.core_stop      = 1'b0;
    bus.wb_start       = 1'b0;
    bus.busy           = 1'b1;
    bus.found_valid    = 1'b0;
    bus.not_found      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.rom_load_start = 1'b1;
        if (bus.rom_load_done) state_d = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_SEARCH;
      S_SEARCH: begin
        if (hit)                   state_d = S_STOP;
        else if (all_done || limit) state_d = S_EXHAUSTED;
      end
      S_STOP: begin
        bus.core_stop = 1'b1;
        bus.wb_start  = 1'b1;
        state_d       = S_WB;
      end
      S_WB: begin
        bus.core_stop = 1'b1;
        if (bus.wb_done) state_d = S_FOUND;
      end
      S_FOUND: begin
        bus.busy        = 1'b0;
        bus.core_stop   = 1'b1;
        bus.found_valid = 1'b1;
        if (bus.start) state_d = S_LOAD;
      end
      S_EXHAUSTED: begin
        bus.busy      = 1'b0;
        bus.core_stop = 1'b1;
        bus.not_found = 1'b1;
        if (bus.start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      core_start_q  <= 1'b0;
      timeout_q     <= 1'b0;
      found_index_q <= '0;
      found_key_q   <= '0;
    end else begin
      core_start_q <= (state_q == S_LAUNCH);
      if (state_q == S_SEARCH) begin
        if (hit) begin
          found_key_q   <= hit_key & KEY_MASK;
          found_index_q <= hit_idx;
        end else if (state_d == S_EXHAUSTED) begin
          found_key_q <= '0;
          timeout_q   <= limit;
        end
      end else if ((state_q == S_FOUND || state_q == S_EXHAUSTED) && bus.start) begin
        timeout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.core_base_key = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      bus.core_base_key[i*KEY_W +: KEY_W] = KEY_W'(i);
    end
  end

  assign bus.core_key_step = KEY_W'(NUM_CORES);
  assign bus.core_start    = core_start_q;
  assign bus.found_key     = found_key_q;
  assign bus.found_index   = found_index_q;
  assign bus.wb_sel        = found_index_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_rc4_search_controller.sv
// Directed bench for rc4_search_controller: cycle table plus latency, reset and timeout sequences.
module tb_rc4_search_controller;
  localparam int unsigned NC = 4;
  localparam int unsigned KW = 24;
  localparam int unsigned IW = 4;

  localparam logic [23:0] K0 = 24'h000100;
  localparam logic [23:0] K1 = 24'h01F2E1;
  localparam logic [23:0] K2 = 24'h000A3C;
  localparam logic [23:0] K3 = 24'h2ABCDE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc4_search_controller_if #(.NUM_CORES(NC), .KEY_W(KW), .IDX_W(IW)) bus ();

  rc4_search_controller #(
    .NUM_CORES(NC), .KEY_W(KW), .SEARCH_W(22), .IDX_W(IW), .TIMEOUT_CYC(100)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // {rom_load_start, core_start, core_stop, wb_start, busy, found_valid, not_found, timeout}
  logic [7:0] flags;
  assign flags = {bus.rom_load_start, bus.core_start, bus.core_stop, bus.wb_start,
                  bus.busy, bus.found_valid, bus.not_found, bus.timeout};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        start;
    logic        rld;
    logic        wbd;
    logic [3:0]  done;
    logic [3:0]  found;
    logic [7:0]  exp;
    logic [1:0]  ck;
    logic [3:0]  eidx;
    logic [23:0] ekey;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic r, input logic w,
                     input logic [3:0] d, input logic [3:0] f, input logic [7:0] e,
                     input logic [1:0] ck, input logic [3:0] ix, input logic [23:0] k,
                     input string nm);
    vec_t v;
    v.start = s; v.rld = r; v.wbd = w; v.done = d; v.found = f;
    v.exp = e; v.ck = ck; v.eidx = ix; v.ekey = k; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.rom_load_done = 1'b0; bus.wb_done = 1'b0;
    bus.core_done = '0; bus.core_found = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_to_search();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.rom_load_done = 1'b1;
    step();
    bus.rom_load_done = 1'b0;
    step();
  endtask

  logic [3:0] cs_seen;
  int         waited;

  initial begin
    clear_inputs();
    bus.core_key = {K3, K2, K1, K0};

    // Cycle table: rows are inputs held for one clock, then outputs after the edge.
    add(1,0,0, 4'h0,4'h0, 8'b10001000, 2'b11, 4'd0, 24'h0, "load");
    add(1,0,0, 4'h0,4'h0, 8'b10001000, 2'b00, 4'd0, 24'h0, "start_in_load_ignored");
    add(0,1,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "launch");
    add(0,0,0, 4'h0,4'h0, 8'b01001000, 2'b00, 4'd0, 24'h0, "search_core_start");
    add(0,0,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "search_wait");
    add(0,0,0, 4'h0,4'h4, 8'b00111000, 2'b11, 4'd2, K2,    "hit_core2_stop");
    add(0,0,0, 4'h0,4'h0, 8'b00101000, 2'b11, 4'd2, K2,    "wb_wait");
    add(1,0,0, 4'h0,4'h0, 8'b00101000, 2'b00, 4'd0, 24'h0, "start_in_wb_ignored");
    add(0,0,1, 4'h0,4'h0, 8'b00100100, 2'b11, 4'd2, K2,    "found_core2");
    add(0,0,0, 4'h0,4'h0, 8'b00100100, 2'b11, 4'd2, K2,    "found_held");
    add(1,0,0, 4'h0,4'h0, 8'b10001000, 2'b11, 4'd2, K2,    "restart_from_found");
    add(0,1,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "launch2");
    add(0,0,0, 4'h0,4'h0, 8'b01001000, 2'b00, 4'd0, 24'h0, "search2_core_start");
    add(0,0,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "search2_wait");
    add(0,0,0, 4'h0,4'hA, 8'b00111000, 2'b11, 4'd1, K1,    "hit_1010_lowest");
    add(0,0,0, 4'h0,4'h0, 8'b00101000, 2'b00, 4'd0, 24'h0, "wb2");
    add(0,0,1, 4'h0,4'h0, 8'b00100100, 2'b11, 4'd1, K1,    "found_core1");
    add(1,0,0, 4'h0,4'h0, 8'b10001000, 2'b00, 4'd0, 24'h0, "load3");
    add(0,1,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "launch3");
    add(0,0,0, 4'h0,4'h0, 8'b01001000, 2'b00, 4'd0, 24'h0, "search3_core_start");
    add(0,0,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "search3_wait");
    add(0,0,0, 4'hF,4'h0, 8'b00100010, 2'b01, 4'd0, 24'h0, "all_done_exhausted");
    add(0,0,0, 4'hF,4'h0, 8'b00100010, 2'b01, 4'd0, 24'h0, "exhausted_held");
    add(1,0,0, 4'h0,4'h0, 8'b10001000, 2'b00, 4'd0, 24'h0, "restart_from_exhausted");
    add(0,1,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "launch4");
    add(0,0,0, 4'h0,4'h0, 8'b01001000, 2'b00, 4'd0, 24'h0, "search4_core_start");
    add(0,0,0, 4'h0,4'h0, 8'b00001000, 2'b00, 4'd0, 24'h0, "search4_wait");
    add(0,0,0, 4'hF,4'h1, 8'b00111000, 2'b11, 4'd0, K0,    "found_beats_done");
    add(0,0,0, 4'h0,4'h0, 8'b00101000, 2'b00, 4'd0, 24'h0, "wb4");
    add(0,0,1, 4'h0,4'h0, 8'b00100100, 2'b11, 4'd0, K0,    "found_core0");

    // Reset state and constant outputs
    #23;
    chk("reset_flags", 96'(flags), 96'h0);
    chk("reset_found_key", 96'(bus.found_key), 96'h0);
    chk("reset_found_index", 96'(bus.found_index), 96'h0);
    chk("reset_wb_sel", 96'(bus.wb_sel), 96'h0);
    chk("core_base_key", 96'(bus.core_base_key), {24'd3, 24'd2, 24'd1, 24'd0});
    chk("core_key_step", 96'(bus.core_key_step), 96'd4);
    release_reset();
    chk("idle_flags", 96'(flags), 96'h0);

    // Latency: start -> rom_load_start, 40-cycle ROM load, single core_start pulse
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_to_rom_load_start", 96'(bus.rom_load_start), 96'd1);
    for (int i = 0; i < 39; i++) step();
    chk("rom_load_start_held", 96'(bus.rom_load_start), 96'd1);
    bus.rom_load_done = 1'b1;
    cs_seen = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.rom_load_done = 1'b0;
      if (i == 0) chk("rom_load_start_drop", 96'(bus.rom_load_start), 96'd0);
      cs_seen[i] = bus.core_start;
    end
    chk("core_start_single_pulse", 96'(cs_seen), 96'b0010);
    chk("search_busy", 96'(flags), 96'b00001000);

    // Reset asserted during SEARCH
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_search_flags", 96'(flags), 96'h0);
    release_reset();

    foreach (tbl[i]) begin
      bus.start         = tbl[i].start;
      bus.rom_load_done = tbl[i].rld;
      bus.wb_done       = tbl[i].wbd;
      bus.core_done     = tbl[i].done;
      bus.core_found    = tbl[i].found;
      step();
      chk($sformatf("%s flags", tbl[i].nm), 96'(flags), 96'(tbl[i].exp));
      if (tbl[i].ck[1]) begin
        chk($sformatf("%s index", tbl[i].nm), 96'(bus.found_index), 96'(tbl[i].eidx));
        chk($sformatf("%s wb_sel", tbl[i].nm), 96'(bus.wb_sel), 96'(tbl[i].eidx));
      end
      if (tbl[i].ck[0]) chk($sformatf("%s key", tbl[i].nm), 96'(bus.found_key), 96'(tbl[i].ekey));
    end
    clear_inputs();

    // Reset asserted during WB after a hit
    run_to_search();
    step();
    bus.core_found = 4'b0100;
    step();
    bus.core_found = '0;
    chk("pre_reset_wb_start", 96'(bus.wb_start), 96'd1);
    step();
    chk("pre_reset_wb_state", 96'(flags), 96'b00101000);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_wb_flags", 96'(flags), 96'h0);
    chk("reset_in_wb_key", 96'(bus.found_key), 96'h0);
    release_reset();

    // Full search again after reset release, with a bounded wait for found_valid
    run_to_search();
    step();
    bus.core_found = 4'b1000;
    step();
    bus.core_found = '0;
    bus.wb_done = 1'b1;
    waited = 0;
    while (!bus.found_valid && waited < 10) begin
      step();
      waited++;
    end
    bus.wb_done = 1'b0;
    chk("post_reset_found_valid", 96'(bus.found_valid), 96'd1);
    chk("post_reset_found_key", 96'(bus.found_key), 96'(K3));
    chk("post_reset_found_index", 96'(bus.found_index), 96'd3);

    // Idle search with no flags: timeout when enabled, otherwise stays searching
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.rom_load_done = 1'b1;
    step();
    bus.rom_load_done = 1'b0;
    step();
    chk("timeout_search_entry", 96'(flags), 96'b01001000);
`ifdef SEARCH_TIMEOUT_EN
    for (int i = 0; i < 99; i++) step();
    chk("before_limit", 96'(flags), 96'b00001000);
    step();
    chk("timeout_exhausted", 96'(flags), 96'b00100011);
    chk("timeout_key", 96'(bus.found_key), 96'h0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("timeout_cleared_on_start", 96'(flags), 96'b10001000);
`else
    for (int i = 0; i < 150; i++) step();
    chk("no_timeout_exit", 96'(flags), 96'b00001000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
